// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// State encoding and redirect priority selection.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_HOLD    = 3'd3,
        S_DISCARD = 3'd4
    } fetch_state_e;

    // Larger encoding wins when several redirects coincide.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_BRANCH = 2'd1,
        RD_JUMP   = 2'd2,
        RD_JR     = 2'd3
    } redir_e;

    localparam redir_e PRIO_HIGH = RD_JR;
    localparam redir_e PRIO_MID  = RD_JUMP;
    localparam redir_e PRIO_LOW  = RD_BRANCH;

    function automatic redir_e redir_pick(
        input logic br,
        input logic jmp,
        input logic jreg
    );
        redir_e r;
        r = RD_NONE;
        if (jreg) begin
            r = PRIO_HIGH;
        end else if (jmp) begin
            r = PRIO_MID;
        end else if (br) begin
            r = PRIO_LOW;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction hold buffer used while decode stalls.
// Clear wins over load.
module fetch_hold_buf #(
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                clear,
    input  logic [INST_LEN-1:0] din,
    output logic [INST_LEN-1:0] dout,
    output logic                valid
);

    logic [INST_LEN-1:0] data_q;
    logic                vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (clear) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else if (load) begin
            data_q <= din;
            vld_q  <= 1'b1;
        end
    end

    assign dout  = data_q;
    assign valid = vld_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding read, PC mux steering,
// decode-stall hold and redirect squashing.
import fetch_pkg::*;

module fetch_ctrl #(
    parameter int INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                branch_taken,
    input  logic                jump,
    input  logic                jr,
    input  logic                id_stall,
    input  logic                imem_valid,
    input  logic [INST_LEN-1:0] imem_rdata,
    output logic                imem_issue,
    output logic                pc_stall,
    output logic                sel_branch,
    output logic                sel_jump,
    output logic                sel_jr,
    output logic                if_id_valid,
    output logic [INST_LEN-1:0] if_id_inst,
    output logic                if_id_flush
);

    fetch_state_e state, state_nxt;
    redir_e       redir;
    logic         redirect;
    logic         buf_load;
    logic         buf_clr;
    logic         buf_vld;
    logic [INST_LEN-1:0] buf_q;

    assign redir    = redir_pick(branch_taken, jump, jr);
    assign redirect = (redir != RD_NONE);

    fetch_hold_buf #(
        .INST_LEN(INST_LEN)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .clear (buf_clr),
        .din   (imem_rdata),
        .dout  (buf_q),
        .valid (buf_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_issue  = 1'b0;
        pc_stall    = 1'b1;
        sel_branch  = 1'b0;
        sel_jump    = 1'b0;
        sel_jr      = 1'b0;
        if_id_valid = 1'b0;
        if_id_inst  = '0;
        if_id_flush = 1'b0;
        buf_load    = 1'b0;
        buf_clr     = 1'b0;

        // Outputs stay at their idle values for the whole reset cycle.
        if (rst_n) begin
            if (redirect) begin
                pc_stall    = 1'b0;
                if_id_flush = 1'b1;
            end

            unique case (redir)
                RD_JR:     sel_jr     = 1'b1;
                RD_JUMP:   sel_jump   = 1'b1;
                RD_BRANCH: sel_branch = 1'b1;
                default:   ;
            endcase

            unique case (state)
                S_IDLE: begin
                    state_nxt = S_ISSUE;
                end
                S_ISSUE: begin
                    imem_issue = 1'b1;
                    state_nxt  = redirect ? S_DISCARD : S_WAIT;
                end
                S_WAIT: begin
                    if_id_inst = imem_rdata;
                    if (redirect) begin
                        state_nxt = imem_valid ? S_ISSUE : S_DISCARD;
                    end else if (imem_valid) begin
                        if (!id_stall) begin
                            if_id_valid = 1'b1;
                            pc_stall    = 1'b0;
                            state_nxt   = S_ISSUE;
                        end else begin
                            buf_load  = 1'b1;
                            state_nxt = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if_id_inst = buf_q;
                    if (redirect) begin
                        buf_clr   = 1'b1;
                        state_nxt = S_ISSUE;
                    end else if (!id_stall) begin
                        if_id_valid = buf_vld;
                        pc_stall    = 1'b0;
                        buf_clr     = 1'b1;
                        state_nxt   = S_ISSUE;
                    end
                end
                S_DISCARD: begin
                    // Late response belongs to a squashed PC.
                    if (imem_valid) begin
                        state_nxt = S_ISSUE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage. It issues one instruction-memory read at a time and steers the PC next-address muxes (sequential, branch, jump, jr). It freezes the PC on decode stalls and cancels in-flight fetches when a redirect arrives. It sits between the hazard/branch logic and the IF stage: it drives the PC `stall` and mux selects, and feeds the IF/ID register through a one-entry hold buffer.

## Interface
- `INST_LEN`, 32: instruction word width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `branch_taken` input 1: branch condition resolved true this cycle.
- `jump` input 1: J-type redirect this cycle.
- `jr` input 1: register-jump redirect this cycle.
- `id_stall` input 1: decode cannot accept an instruction this cycle.
- `imem_valid` input 1: response for the outstanding read, valid for one cycle.
- `imem_rdata` input `INST_LEN`: read data, qualified by `imem_valid`.
- `imem_issue` output 1: one-cycle pulse; memory samples the current PC as the read address.
- `pc_stall` output 1: drives the PC `stall` input. 1 holds the PC; 0 loads the next PC.
- `sel_branch` output 1: branch-target mux select.
- `sel_jump` output 1: jump mux select.
- `sel_jr` output 1: jr mux select.
- `if_id_valid` output 1: `if_id_inst` is valid; the IF/ID register writes this cycle.
- `if_id_inst` output `INST_LEN`: instruction to IF/ID.
- `if_id_flush` output 1: squash the IF/ID contents.

## Operation
- Redirect is `branch_taken | jump | jr`. Priority is jr > jump > branch.
  - Exactly one of `sel_jr`/`sel_jump`/`sel_branch` is 1, and only in a cycle where `pc_stall=0` due to a redirect.
  - All three selects are 0 otherwise, including on sequential advances.
- Any redirect cycle forces `pc_stall=0`, `if_id_flush=1`, `if_id_valid=0`. The redirect overrides `id_stall`.
- At most one memory read is outstanding.
- States and transitions:
  - IDLE: entered on reset. Next cycle goes to ISSUE.
  - ISSUE: `imem_issue=1`.
    - Redirect: load target, go to DISCARD.
    - Otherwise: go to WAIT.
  - WAIT:
    - Redirect with `imem_valid`: drop the data, go to ISSUE.
    - Redirect without `imem_valid`: go to DISCARD.
    - `imem_valid` and `!id_stall`: pass `imem_rdata` to IF/ID with `if_id_valid=1` and `pc_stall=0` (sequential), go to ISSUE.
    - `imem_valid` and `id_stall`: capture the data into the hold buffer, go to HOLD.
  - HOLD: PC frozen.
    - Redirect: clear the buffer, go to ISSUE.
    - `!id_stall`: present the buffer with `if_id_valid=1` and `pc_stall=0`, go to ISSUE.
  - DISCARD: the in-flight response belongs to a squashed PC.
    - A further redirect loads the new target and stays in DISCARD; the latest redirect wins.
    - `imem_valid`: drop the data, go to ISSUE. `if_id_valid` stays 0.
- `pc_stall=1` in every cycle not listed above as loading the PC.

## Timing
- Reset values: state IDLE, `pc_stall=1`, all selects 0, `imem_issue=0`, `if_id_valid=0`, `if_id_flush=0`, `if_id_inst=0`, hold buffer empty.
- Reset mid-operation: a pending response is ignored. The first `imem_issue` occurs 2 cycles after `rst_n` rises (IDLE, then ISSUE).
- `imem_valid` is legal no earlier than the cycle after `imem_issue`.
  - `imem_valid` in any state other than WAIT or DISCARD is a protocol error: ignored, state unchanged.
- Throughput is 1 instruction per 2 cycles with zero-wait memory. Each extra memory wait cycle adds 1.
- All outputs are decoded from the registered state and the same-cycle inputs, with no extra registering.
  - The PC updates at the clock edge that ends a `pc_stall=0` cycle.
  - `if_id_inst` in WAIT is `imem_rdata` combinationally. In HOLD it is the buffer.

## Structure
- `fetch_pkg`, the shared package, holds:
  - the state encoding (IDLE, ISSUE, WAIT, HOLD, DISCARD), 3 bits;
  - redirect priority constants.
- One sub-module, `fetch_hold_buf`: a one-entry `INST_LEN` register with load/clear/valid, used for HOLD.
- The top level holds the FSM and the output decode.

## Test plan
- Reset release with `imem_valid` 1 cycle after each issue and no stalls:
  - first `imem_issue` at cycle 2;
  - `if_id_valid` with data 0x20080005 at cycle 3;
  - `pc_stall=0` at cycles 3, 5, 7.
- `id_stall` high for 3 cycles when data 0x8C090000 returns:
  - HOLD for 3 cycles with `pc_stall=1` and `if_id_valid=0`;
  - on release, `if_id_valid=1` with 0x8C090000, then ISSUE.
- `jump` while in WAIT with memory latency 3:
  - `sel_jump=1`, `pc_stall=0`, `if_id_flush=1` that cycle;
  - the late response is dropped (`if_id_valid` stays 0);
  - the next `imem_issue` is 1 cycle after the dropped response.
- `jr`, `jump` and `branch_taken` asserted in the same cycle:
  - only `sel_jr=1`;
  - during HOLD, the buffered instruction is discarded and never presented.
- Two redirects in DISCARD (branch, then jr 1 cycle later): PC loaded twice with `sel_branch`, then `sel_jr`; a single drop follows, then ISSUE.
- `rst_n` low for 1 cycle while in WAIT: all outputs return to reset values; the response arriving after reset is ignored.
